i2s_tx_slave: RTL

I2S slave transmitter: the counterpart of the SoC's I2S master receiver. It takes BCLK and WS from an external I2S master and serialises stereo PCM frames from a small on-chip FIFO onto the data line, MSB first, in standard Philips I2S framing. It sits on the system clock domain as a synthesizable microphone/codec source and feeds the SoC's `I2S_in` in loopback and system benches. Software or a producer block pushes frames through a valid/ready port.

---
 rtl/i2s_tx_slave_pkg.sv | 29 ++
 rtl/i2s_tx_slave_if.sv | 38 +++
 rtl/i2s_tx_slave_fifo.sv | 72 +++++++
 rtl/i2s_tx_slave.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_tx_slave_pkg.sv
// Shared types and defaults for the I2S slave transmitter.
// I2S_TX_MONO_EN selects single-sample FIFO entries instead of {left, right} frames.
package i2s_tx_pkg;

  localparam int DEF_DATA_W     = 24;
  localparam int DEF_SLOT_W     = 32;
  localparam int DEF_FIFO_DEPTH = 4;

  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } channel_e;

  typedef enum logic [1:0] {
    DISARMED,
    WAIT_LEFT,
    RUN
  } state_e;

  // Width of one FIFO entry / push word for a given sample width.
  function automatic int frame_w(input int data_w);
`ifdef I2S_TX_MONO_EN
    return data_w;
`else
    return 2 * data_w;
`endif
  endfunction

endpackage

// File: rtl/i2s_tx_slave_if.sv
// Producer-side push port of the I2S slave transmitter, with status and flag clear.
// Under I2S_TX_MONO_EN the push word carries one sample instead of {left, right}.
interface i2s_tx_slave_if
  import i2s_tx_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) ();

  localparam int FRAME_W = frame_w(DATA_W);
  localparam int LEVEL_W = $clog2(FIFO_DEPTH + 1);

  logic [FRAME_W-1:0] s_data;
  logic               s_valid;
  logic               s_ready;
  logic [LEVEL_W-1:0] level;
  logic               underflow;
  logic               clr_underflow;

  modport master (
    output s_data,
    output s_valid,
    output clr_underflow,
    input  s_ready,
    input  level,
    input  underflow
  );

  modport slave (
    input  s_data,
    input  s_valid,
    input  clr_underflow,
    output s_ready,
    output level,
    output underflow
  );

endinterface

// File: rtl/i2s_tx_slave_fifo.sv
// Small synchronous FIFO with array storage and a registered read port:
// rdata holds the popped entry from the cycle after the pop onwards.
module i2s_tx_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       srst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LEVEL_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_reg;
  logic [PTR_W-1:0]   rd_ptr_reg;
  logic [LEVEL_W-1:0] level_reg;
  logic [LEVEL_W-1:0] level_next;
  logic [WIDTH-1:0]   rdata_reg;
  logic               push_ok;
  logic               pop_ok;

  assign full    = (level_reg == LEVEL_W'(DEPTH));
  assign empty   = (level_reg == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    level_next = level_reg;
    case ({push_ok, pop_ok})
      2'b10:   level_next = level_reg + 1'b1;
      2'b01:   level_next = level_reg - 1'b1;
      default: level_next = level_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= wdata;
    end
  end

  // Depth is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
      rdata_reg  <= '0;
    end else begin
      level_reg <= level_next;
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
        rdata_reg  <= mem[rd_ptr_reg];
      end
    end
  end

  assign rdata = rdata_reg;
  assign level = level_reg;

endmodule

// File: rtl/i2s_tx_slave.sv
// I2S (Philips) slave transmitter: syncs external BCLK/WS, pops PCM frames at each
// left start and shifts them out MSB first on BCLK falls. I2S_TX_MONO_EN: mono FIFO.
module i2s_tx_slave
  import i2s_tx_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int SLOT_W     = DEF_SLOT_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic HCLK,
  input  logic HRESET,
  input  logic bclk,
  input  logic ws,
  output logic dout,
  i2s_tx_slave_if.slave bus
);

  localparam int FRAME_W = frame_w(DATA_W);
  localparam int LEVEL_W = $clog2(FIFO_DEPTH + 1);

  logic [1:0] pins;
  logic [1:0] synced;
  genvar gi;

  assign pins = {ws, bclk};

  generate
    for (gi = 0; gi < 2; gi++) begin : g_sync
      logic meta_reg;
      logic sync_reg;
      always_ff @(posedge HCLK) begin
        if (HRESET) begin
          meta_reg <= 1'b0;
          sync_reg <= 1'b0;
        end else begin
          meta_reg <= pins[gi];
          sync_reg <= meta_reg;
        end
      end
      assign synced[gi] = sync_reg;
    end
  endgenerate

  logic     bclk_s;
  channel_e ws_cur;
  logic     bclk_prev_reg;
  channel_e ws_last_reg;
  logic     fall;
  logic     left_start;
  logic     right_start;

  assign bclk_s      = synced[0];
  assign ws_cur      = channel_e'(synced[1]);
  assign fall        = bclk_prev_reg && !bclk_s;
  assign left_start  = fall && (ws_last_reg == CH_RIGHT) && (ws_cur == CH_LEFT);
  assign right_start = fall && (ws_last_reg == CH_LEFT) && (ws_cur == CH_RIGHT);

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      bclk_prev_reg <= 1'b0;
      ws_last_reg   <= CH_LEFT;
    end else begin
      bclk_prev_reg <= bclk_s;
      if (fall) begin
        ws_last_reg <= ws_cur;
      end
    end
  end

  logic [FRAME_W-1:0] fifo_rdata;
  logic               fifo_full;
  logic               fifo_empty;
  logic [LEVEL_W-1:0] fifo_level;
  logic               pop_req;

  i2s_tx_fifo #(
    .WIDTH (FRAME_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (HCLK),
    .srst  (HRESET),
    .push  (bus.s_valid && bus.s_ready),
    .wdata (bus.s_data),
    .pop   (pop_req),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign bus.s_ready = !fifo_full;
  assign bus.level   = fifo_level;

  state_e state_reg;
  state_e state_next;
  logic   load_zero;
  logic   load_right;
  logic   shift_en;
  logic   dout_zero;
  logic   set_underflow;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_reg <= DISARMED;
    end else begin
      state_reg <= state_next;
    end
  end

  // The first fall after reset only establishes ws_last; data waits for a left start.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      DISARMED:  if (fall) state_next = WAIT_LEFT;
      WAIT_LEFT: if (left_start) state_next = RUN;
      RUN:       state_next = RUN;
      default:   state_next = DISARMED;
    endcase
  end

  always_comb begin
    pop_req       = 1'b0;
    load_zero     = 1'b0;
    load_right    = 1'b0;
    shift_en      = 1'b0;
    dout_zero     = 1'b0;
    set_underflow = 1'b0;
    unique case (state_reg)
      WAIT_LEFT: begin
        if (left_start) begin
          dout_zero = 1'b1;
          if (fifo_empty) begin
            load_zero     = 1'b1;
            set_underflow = 1'b1;
          end else begin
            pop_req = 1'b1;
          end
        end else if (fall) begin
          dout_zero = 1'b1;
        end
      end
      RUN: begin
        if (left_start) begin
          dout_zero = 1'b1;
          if (fifo_empty) begin
            load_zero     = 1'b1;
            set_underflow = 1'b1;
          end else begin
            pop_req = 1'b1;
          end
        end else if (right_start) begin
          load_right = 1'b1;
          dout_zero  = 1'b1;
        end else if (fall) begin
          shift_en = 1'b1;
        end
      end
      default: ;
    endcase
  end

  logic [DATA_W-1:0] sample_left;
  logic [DATA_W-1:0] sample_right;

`ifdef I2S_TX_MONO_EN
  assign sample_left  = fifo_rdata;
  assign sample_right = fifo_rdata;
`else
  assign sample_left  = fifo_rdata[FRAME_W-1 -: DATA_W];
  assign sample_right = fifo_rdata[DATA_W-1:0];
`endif

  function automatic logic [SLOT_W-1:0] to_slot(input logic [DATA_W-1:0] sample);
    to_slot = '0;
    to_slot[SLOT_W-1 -: DATA_W] = sample;
  endfunction

  logic [SLOT_W-1:0] shreg_reg;
  logic [DATA_W-1:0] right_hold_reg;
  logic              pop_d_reg;
  logic              dout_reg;
  logic              underflow_reg;

  // Popped data arrives one cycle after the left-start fall; the next fall is
  // several HCLK cycles away, so the late shift-register load is never observed.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      shreg_reg      <= '0;
      right_hold_reg <= '0;
      pop_d_reg      <= 1'b0;
      dout_reg       <= 1'b0;
      underflow_reg  <= 1'b0;
    end else begin
      pop_d_reg <= pop_req;

      if (dout_zero) begin
        dout_reg <= 1'b0;
      end else if (shift_en) begin
        dout_reg <= shreg_reg[SLOT_W-1];
      end

      if (load_zero) begin
        shreg_reg      <= '0;
        right_hold_reg <= '0;
      end else if (pop_d_reg) begin
        shreg_reg      <= to_slot(sample_left);
        right_hold_reg <= sample_right;
      end else if (load_right) begin
        shreg_reg <= to_slot(right_hold_reg);
      end else if (shift_en) begin
        shreg_reg <= shreg_reg << 1;
      end

      if (set_underflow) begin
        underflow_reg <= 1'b1;
      end else if (bus.clr_underflow) begin
        underflow_reg <= 1'b0;
      end
    end
  end

  assign dout          = dout_reg;
  assign bus.underflow = underflow_reg;

endmodule
